stream_pool2x2: RTL and testbench

STREAM_POOL2X2 -- requirements
Module: stream_pool2x2

---
 rtl/stream_pool2x2.sv | 159 +++++++++++++++
 tb/tb_stream_pool2x2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pool2x2.sv
// stream_pool2x2: streaming 2x2 non-overlapping pooling (max or average)
// over a raster-ordered pixel stream with valid/ready handshakes on both
// sides. The even rows are reduced pairwise into a half-width line buffer.
// The odd rows combine that buffer with the current pair and emit one
// pooled pixel per 2x2 window.
module stream_pool2x2 #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned IMG_W  = 16,
   parameter int unsigned IMG_H  = 16,
   parameter int unsigned CH     = 1,
   parameter int unsigned MODE   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_W*CH-1:0]   s_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_W*CH-1:0]   m_data,
   output logic                   m_last,
   output logic                   frame_done,
   output logic                   busy
);

   localparam int unsigned COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int unsigned LB_N  = IMG_W / 2;
   localparam int unsigned LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
   // Max mode keeps the partial max at sample width; average mode keeps
   // the full pair sum so no precision is lost before the final divide.
   localparam int unsigned LB_W  = (MODE == 0) ? DATA_W : DATA_W + 1;
   localparam int unsigned SUM_W = DATA_W + 2;

   logic [COL_W-1:0]       r_col;
   logic [ROW_W-1:0]       r_row;
   logic [DATA_W*CH-1:0]   r_pair;
   logic [LB_W*CH-1:0]     r_lb [LB_N];
   logic                   r_m_valid;
   logic [DATA_W*CH-1:0]   r_m_data;
   logic                   r_m_last;
   logic                   r_frame_done;
   logic                   r_busy;

   logic                   w_in_xfer;
   logic                   w_out_xfer;
   logic                   w_col_last;
   logic                   w_row_last;
   logic                   w_col_odd;
   logic                   w_row_odd;
   logic                   w_win_load;
   logic [LB_AW-1:0]       w_lb_idx;
   logic [LB_W*CH-1:0]     w_lb_rd;
   logic [LB_W*CH-1:0]     w_pair_res;
   logic [DATA_W*CH-1:0]   w_win_res;

   assign s_ready    = !r_m_valid || m_ready;
   assign w_in_xfer  = s_valid && s_ready;
   assign w_out_xfer = r_m_valid && m_ready;

   assign w_col_last = (r_col == COL_W'(IMG_W - 1));
   assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
   assign w_col_odd  = r_col[0];
   assign w_row_odd  = r_row[0];
   assign w_win_load = w_in_xfer && w_row_odd && w_col_odd;
   assign w_lb_idx   = LB_AW'(r_col >> 1);
   assign w_lb_rd    = r_lb[w_lb_idx];

   // Per-channel datapath: pair reduction for the line buffer and the
   // final 2x2 window result; channels never interact.
   for (genvar k = 0; k < CH; k++) begin : g_ch
      logic [DATA_W-1:0] w_pix;
      logic [DATA_W-1:0] w_prv;
      logic [LB_W-1:0]   w_lb_ent;

      assign w_pix    = s_data[k*DATA_W +: DATA_W];
      assign w_prv    = r_pair[k*DATA_W +: DATA_W];
      assign w_lb_ent = w_lb_rd[k*LB_W +: LB_W];

      if (MODE == 0) begin : g_max
         logic [DATA_W-1:0] w_mx;
         assign w_mx = (w_prv > w_pix) ? w_prv : w_pix;
         assign w_pair_res[k*LB_W +: LB_W]     = w_mx;
         assign w_win_res[k*DATA_W +: DATA_W]  = (w_lb_ent > w_mx) ? w_lb_ent : w_mx;
      end else begin : g_avg
         logic [SUM_W-1:0] w_sum4;
         assign w_pair_res[k*LB_W +: LB_W]    = {1'b0, w_prv} + {1'b0, w_pix};
         assign w_sum4                        = {1'b0, w_lb_ent} + {2'b00, w_prv} + {2'b00, w_pix};
         assign w_win_res[k*DATA_W +: DATA_W] = w_sum4[SUM_W-1:2];
      end
   end

   // Raster position: column/row counters advance on accepted beats only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_in_xfer) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   // Pair register: holds the even-column pixel of every row.
   always_ff @(posedge clk) begin
      if (w_in_xfer && !w_col_odd) begin
         r_pair <= s_data;
      end
   end

   // Line buffer: one reduced pair per window column, written on even rows.
   always_ff @(posedge clk) begin
      if (w_in_xfer && !w_row_odd && w_col_odd) begin
         r_lb[w_lb_idx] <= w_pair_res;
      end
   end

   // Output register: load a window result, or retire the beat once taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_last  <= 1'b0;
      end else if (w_win_load) begin
         r_m_valid <= 1'b1;
         r_m_data  <= w_win_res;
         r_m_last  <= w_row_last && w_col_last;
      end else if (w_out_xfer) begin
         r_m_valid <= 1'b0;
      end
   end

   // Frame status: done pulse after the last beat leaves; busy spans the frame.
   // A beat of the next frame accepted on the closing edge keeps busy high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_frame_done <= w_out_xfer && r_m_last;
         if (w_in_xfer) begin
            r_busy <= 1'b1;
         end else if (w_out_xfer && r_m_last) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign m_last     = r_m_last;
   assign frame_done = r_frame_done;
   assign busy       = r_busy;

endmodule

// File: tb/tb_stream_pool2x2.sv
// tb_stream_pool2x2: directed checks of stream_pool2x2 on a 4x4 frame.
// Three instances run in lockstep on shared handshakes: max/1ch, avg/1ch
// and max/2ch (ch1 = 15 - ch0).
module tb_stream_pool2x2;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid;
   logic       m_ready;
   logic [3:0] s_d1;
   logic [7:0] s_d2;

   logic       sr0, sr1, sr2;
   logic       mv0, mv1, mv2;
   logic       ml0, ml1, ml2;
   logic       fd0, fd1, fd2;
   logic       bz0, bz1, bz2;
   logic [3:0] md0, md1;
   logic [7:0] md2;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [8:0]  q0[$];
   logic [8:0]  q1[$];
   logic [8:0]  q2[$];
   int unsigned fdc0 = 0, fdc1 = 0, fdc2 = 0;
   logic        stall_en = 1'b0;

   logic [7:0] E_MAX [4] = '{8'd5, 8'd7, 8'd13, 8'd15};
   logic [7:0] E_AVG [4] = '{8'd2, 8'd4, 8'd10, 8'd12};
   logic [7:0] E_CH2 [4] = '{8'hF5, 8'hD7, 8'h7D, 8'h5F};
   logic [7:0] E_F   [4] = '{8'd15, 8'd15, 8'd15, 8'd15};
   logic [7:0] E_0F  [4] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F};

   always #5 clk = ~clk;

   stream_pool2x2 #(.DATA_W(4), .IMG_W(4), .IMG_H(4), .CH(1), .MODE(0)) u_max (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr0), .s_data(s_d1),
      .m_valid(mv0), .m_ready(m_ready), .m_data(md0), .m_last(ml0),
      .frame_done(fd0), .busy(bz0));

   stream_pool2x2 #(.DATA_W(4), .IMG_W(4), .IMG_H(4), .CH(1), .MODE(1)) u_avg (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr1), .s_data(s_d1),
      .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .m_last(ml1),
      .frame_done(fd1), .busy(bz1));

   stream_pool2x2 #(.DATA_W(4), .IMG_W(4), .IMG_H(4), .CH(2), .MODE(0)) u_ch2 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr2), .s_data(s_d2),
      .m_valid(mv2), .m_ready(m_ready), .m_data(md2), .m_last(ml2),
      .frame_done(fd2), .busy(bz2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Record every output transfer and frame_done cycle outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         if (mv0 && m_ready) q0.push_back({ml0, 4'b0000, md0});
         if (mv1 && m_ready) q1.push_back({ml1, 4'b0000, md1});
         if (mv2 && m_ready) q2.push_back({ml2, md2});
         if (fd0) fdc0++;
         if (fd1) fdc1++;
         if (fd2) fdc2++;
      end
   end

   // Hold m_ready low for three cycles when the first output of the frame appears.
   initial begin
      wait (stall_en == 1'b1);
      for (int i = 0; i < 200 && !mv0; i++) begin
         @(posedge clk);
         #1;
      end
      check("stall_seen", 32'(mv0), 1);
      m_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_data_max", 32'(md0), 5);
         check("stall_data_avg", 32'(md1), 2);
         check("stall_valid", 32'(mv0), 1);
         check("stall_sready", 32'(sr0), 0);
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
   end

   task automatic push(input logic [3:0] x);
      bit done;
      done    = 1'b0;
      s_valid = 1'b1;
      s_d1    = x;
      s_d2    = {4'd15 - x, x};
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = sr0;
         @(posedge clk);
         #1;
      end
      if (!done) check("push_timeout", 0, 1);
   endtask

   task automatic push_ramp();
      for (int i = 0; i < 16; i++) push(4'(i));
   endtask

   task automatic drain(input int unsigned target);
      s_valid = 1'b0;
      for (int i = 0; i < 40 && fdc0 < target; i++) @(negedge clk);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic clear();
      q0.delete();
      q1.delete();
      q2.delete();
      fdc0 = 0;
      fdc1 = 0;
      fdc2 = 0;
   endtask

   task automatic verify(input string nm, input int unsigned frames,
                         input logic [7:0] e0 [4], input logic [7:0] e1 [4], input logic [7:0] e2 [4]);
      logic [8:0] v;
      check($sformatf("%s count_max", nm), q0.size(), frames * 4);
      check($sformatf("%s count_avg", nm), q1.size(), frames * 4);
      check($sformatf("%s count_ch2", nm), q2.size(), frames * 4);
      for (int f = 0; f < int'(frames); f++) begin
         for (int i = 0; i < 4; i++) begin
            int idx;
            idx = f * 4 + i;
            if (idx < q0.size()) begin
               v = q0[idx];
               check($sformatf("%s max[%0d]", nm, idx), 32'(v[7:0]), 32'(e0[i]));
               check($sformatf("%s max_last[%0d]", nm, idx), 32'(v[8]), 32'(i == 3));
            end
            if (idx < q1.size()) begin
               v = q1[idx];
               check($sformatf("%s avg[%0d]", nm, idx), 32'(v[7:0]), 32'(e1[i]));
               check($sformatf("%s avg_last[%0d]", nm, idx), 32'(v[8]), 32'(i == 3));
            end
            if (idx < q2.size()) begin
               v = q2[idx];
               check($sformatf("%s ch2[%0d]", nm, idx), 32'(v[7:0]), 32'(e2[i]));
               check($sformatf("%s ch2_last[%0d]", nm, idx), 32'(v[8]), 32'(i == 3));
            end
         end
      end
      check($sformatf("%s frame_done_max", nm), fdc0, frames);
      check($sformatf("%s frame_done_avg", nm), fdc1, frames);
      check($sformatf("%s frame_done_ch2", nm), fdc2, frames);
   endtask

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_d1    = '0;
      s_d2    = '0;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst m_valid", 32'(mv0), 0);
      check("rst m_data", 32'(md0), 0);
      check("rst m_data_ch2", 32'(md2), 0);
      check("rst m_last", 32'(ml0), 0);
      check("rst frame_done", 32'(fd0), 0);
      check("rst busy", 32'(bz0), 0);
      check("rst s_ready", 32'(sr0), 1);
      rst = 1'b0;

      // Plain frame, downstream always ready.
      clear();
      for (int i = 0; i < 16; i++) begin
         push(4'(i));
         if (i == 0) check("busy_after_first", 32'(bz0), 1);
      end
      drain(1);
      check("busy_after_frame", 32'(bz0), 0);
      verify("basic", 1, E_MAX, E_AVG, E_CH2);

      // Backpressure on the first output.
      clear();
      stall_en = 1'b1;
      push_ramp();
      drain(1);
      stall_en = 1'b0;
      verify("stall", 1, E_MAX, E_AVG, E_CH2);

      // Full-scale samples: the average sum needs DATA_W+2 bits.
      clear();
      for (int i = 0; i < 16; i++) push(4'd15);
      drain(1);
      verify("fullscale", 1, E_F, E_F, E_0F);

      // Reset after six beats with an output pending, then a clean frame.
      clear();
      for (int i = 0; i < 6; i++) push(4'(i));
      s_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midrst m_valid", 32'(mv0), 0);
      check("midrst busy", 32'(bz0), 0);
      rst = 1'b0;
      clear();
      push_ramp();
      drain(1);
      verify("midrst", 1, E_MAX, E_AVG, E_CH2);

      // Two frames back to back with s_valid held high.
      clear();
      push_ramp();
      push_ramp();
      drain(2);
      verify("b2b", 2, E_MAX, E_AVG, E_CH2);
      check("b2b busy_end", 32'(bz0), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
